decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV32I decode stage; consumes pc2/instr2 from frontend_stage and drives a registered decode->execute pipe.
//  Extracts register addresses, generates the immediate and classifies the instruction.
//  Detects load-use hazards against the instruction in execute.
//  Drives stall/stallnum back to the frontend and holds the stalled instruction in a skid register.
//  Squashes to a bubble on kill (branch/jump taken in execute).
// PARAMETERS
//  LOAD_USE_CYCLES  1           stall cycles inserted per load-use hazard (1..3)
//  NOP_INSTR        32'h00000013 addi x0,x0,0; bubble encoding
// PORTS
//  clk         in   1   single clock, rising edge
//  nrst        in   1   asynchronous active-low reset
//  pc2         in   32  pc of incoming instruction (frontend pipe #2)
//  instr2      in   32  incoming instruction word
//  kill        in   1   flush request from execute (taken branch/jump)
//  stall       out  1   freeze request to frontend (combinational)
//  stallnum    out  2   index of current stall cycle: 0 on first, +1 per cycle, saturates at 3
//  rs1_addr    out  5   register-file read address 1 (combinational, from selected instr)
//  rs2_addr    out  5   register-file read address 2 (combinational)
//  pc3         out  32  registered pc to execute
//  instr3      out  32  registered instruction word to execute
//  rd3         out  5   registered destination register
//  imm3        out  32  registered sign-extended immediate
//  iclass3     out  4   registered instruction class (iclass_t)
//  funct3_3    out  3   registered funct3
//  f7b5_3      out  1   registered instr[30]
//  valid3      out  1   registered: 1 = real instruction, 0 = bubble
// BEHAVIOUR
//  Reset: FSM=RUN, cnt=0. All *3 outputs are 0, except instr3=NOP_INSTR and iclass3=IC_ALUI.
//   stall=0, stallnum=0, skid register=NOP_INSTR/pc 0.
//  Selected instr (sel): skid register when FSM=STALL, else instr2/pc2.
//  Latency: 1 cycle. sel is decoded combinationally and registered into *3 on the next rising clk.
//  Decode is pure function of sel:
//   - rs1=[19:15], rs2=[24:20], rd=[11:7].
//   - imm formats I/S/B/U/J, sign-extended from bit 31.
//   - B/J immediates carry bit0=0.
//   - Unknown opcode -> IC_ILLEGAL, valid=1, imm=0.
//  uses_rs1: all classes except LUI, AUIPC, JAL.
//  uses_rs2: classes BRANCH, STORE, ALUR only.
//  hazard = valid3 & (iclass3==IC_LOAD) & rd3!=0
//   & ((uses_rs1 & rs1==rd3) | (uses_rs2 & rs2==rd3)).
//  FSM RUN:
//   - hazard & !kill: capture instr2/pc2 into skid; load bubble into *3; go STALL; cnt=0.
//   - else: load decoded sel into *3.
//  FSM STALL:
//   - stall=1, stallnum=cnt; *3 loaded with bubble each cycle; cnt++ (saturate 3).
//   - When cnt==LOAD_USE_CYCLES-1: next edge decodes skid into *3 and returns to RUN.
//  stall=1 only in STALL state (registered state -> clean comb output); stallnum=0 in RUN.
//  Bubble: instr3=NOP_INSTR, valid3=0, rd3=0, imm3=0, iclass3=IC_ALUI, pc3=held pc.
//  kill (any state) has priority over hazard and stall.
//   Next edge: *3 <- bubble, FSM <- RUN, cnt <- 0, skid discarded.
//  Back-to-back loads: the bubble clears valid3, so no repeat hazard on the same pair.
//   The skid instr may itself raise a hazard vs the next load as normal.
//  x0 as rd never triggers a hazard.
//  Reset mid-stall: returns immediately to the reset state; the skid content is lost.
// STRUCTURE
//  gpcore_pkg:
//   - iclass_t enum: IC_ALUR, IC_ALUI, IC_LOAD, IC_STORE, IC_BRANCH, IC_JAL, IC_JALR,
//     IC_LUI, IC_AUIPC, IC_SYSTEM, IC_ILLEGAL.
//   - opcode localparams (7'b0110011, ...).
//   - NOP constant; imm format enum.
//  Sub-module imm_gen (combinational: instr, fmt -> imm32).
//  FSM, skid register and pipe register live in decode_stage.
// TESTING
//  1. Reset release, instr2=32'h00500093 (addi x1,x0,5), pc2=4
//     -> next edge: valid3=1, rd3=1, imm3=5, iclass3=IC_ALUI, pc3=4, stall=0.
//  2. lw x5,0(x2) then add x6,x5,x1
//     -> 1 bubble (valid3=0), stall=1 with stallnum=0 for 1 cycle;
//        then add decoded from skid with pc retained.
//  3. lw x0,0(x2) then add x6,x0,x1 -> no stall.
//     lw x5 then lui x5,... -> no stall (no rs use).
//  4. kill asserted during the STALL cycle -> next edge: valid3=0, stall=0, FSM=RUN;
//     the skid instr is never issued.
//  5. LOAD_USE_CYCLES=3, load-use pair -> stallnum 0,1,2 on consecutive cycles;
//     3 bubbles, then the dependent instr.
//  6. Immediates: beq with imm=-4 -> imm3=32'hFFFFFFFC; jal +2048 -> imm3=32'h00000800;
//     sw offset -1 -> 32'hFFFFFFFF; opcode 7'h7F -> iclass3=IC_ILLEGAL.

Source files
------------

// File: rtl/gpcore_pkg.sv
// Shared RV32I decode types: instruction classes, immediate formats, opcodes and
// the opcode classifier used by the decode stage.
package gpcore_pkg;

  typedef enum logic [3:0] {
    IC_ALUR, IC_ALUI, IC_LOAD, IC_STORE, IC_BRANCH, IC_JAL, IC_JALR,
    IC_LUI, IC_AUIPC, IC_SYSTEM, IC_ILLEGAL
  } iclass_t;

  typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;

  typedef enum logic {ST_RUN, ST_STALL} dec_state_t;

  localparam logic [6:0] OP_ALUR   = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    iclass_t  iclass;
    imm_fmt_t fmt;
  } op_info_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] imm;
    iclass_t     iclass;
    logic [2:0]  funct3;
    logic        f7b5;
  } pipe_t;

  function automatic op_info_t classify(input logic [6:0] opcode);
    op_info_t info;
    info = '{iclass: IC_ILLEGAL, fmt: FMT_NONE};
    case (opcode)
      OP_ALUR:   info = '{iclass: IC_ALUR,   fmt: FMT_NONE};
      OP_ALUI:   info = '{iclass: IC_ALUI,   fmt: FMT_I};
      OP_LOAD:   info = '{iclass: IC_LOAD,   fmt: FMT_I};
      OP_STORE:  info = '{iclass: IC_STORE,  fmt: FMT_S};
      OP_BRANCH: info = '{iclass: IC_BRANCH, fmt: FMT_B};
      OP_JAL:    info = '{iclass: IC_JAL,    fmt: FMT_J};
      OP_JALR:   info = '{iclass: IC_JALR,   fmt: FMT_I};
      OP_LUI:    info = '{iclass: IC_LUI,    fmt: FMT_U};
      OP_AUIPC:  info = '{iclass: IC_AUIPC,  fmt: FMT_U};
      OP_SYSTEM: info = '{iclass: IC_SYSTEM, fmt: FMT_I};
      default:   info = '{iclass: IC_ILLEGAL, fmt: FMT_NONE};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Frontend/execute-facing signals of the decode stage, grouped with modports for
// the driving side (master) and the decode stage itself (slave).
interface decode_stage_if;
  import gpcore_pkg::*;

  logic [31:0] pc2;
  logic [31:0] instr2;
  logic        kill;
  logic        stall;
  logic [1:0]  stallnum;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] pc3;
  logic [31:0] instr3;
  logic [4:0]  rd3;
  logic [31:0] imm3;
  iclass_t     iclass3;
  logic [2:0]  funct3_3;
  logic        f7b5_3;
  logic        valid3;

  modport master (
    output pc2, instr2, kill,
    input  stall, stallnum, rs1_addr, rs2_addr, pc3, instr3, rd3, imm3,
           iclass3, funct3_3, f7b5_3, valid3
  );

  modport slave (
    input  pc2, instr2, kill,
    output stall, stallnum, rs1_addr, rs2_addr, pc3, instr3, rd3, imm3,
           iclass3, funct3_3, f7b5_3, valid3
  );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// RV32I immediate generator: reassembles the I/S/B/U/J immediate fields and
// sign-extends from instr[31]; FMT_NONE yields zero.
module imm_gen
  import gpcore_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_fmt_t    fmt,
    output logic [31:0] imm
);

    always_comb begin
        // NOTE: default first so every path assigns imm and no latch is inferred.
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the selected instruction into a registered
// decode->execute pipe, inserting load-use stalls via a skid register.
module decode_stage
  import gpcore_pkg::*;
#(
    parameter int          LOAD_USE_CYCLES = 1,
    parameter logic [31:0] NOP_INSTR       = NOP_WORD
) (
    input logic           clk,
    input logic           nrst,
    decode_stage_if.slave dif
);

    localparam logic [1:0] LAST_CNT = 2'(LOAD_USE_CYCLES - 1);

    dec_state_t  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] skid_instr_q, skid_pc_q;
    logic        skid_load, load_bubble;
    pipe_t       pipe_q, pipe_d;
    logic [31:0] sel_instr, sel_pc, sel_imm;
    op_info_t    sel_info;
    logic        uses_rs1, uses_rs2, hazard;

    assign sel_instr = (state_q == ST_STALL) ? skid_instr_q : dif.instr2;
    assign sel_pc    = (state_q == ST_STALL) ? skid_pc_q    : dif.pc2;
    assign sel_info  = classify(sel_instr[6:0]);

    imm_gen u_imm_gen (
        .instr (sel_instr),
        .fmt   (sel_info.fmt),
        .imm   (sel_imm)
    );

    assign uses_rs1 = !(sel_info.iclass inside {IC_LUI, IC_AUIPC, IC_JAL});
    assign uses_rs2 = sel_info.iclass inside {IC_BRANCH, IC_STORE, IC_ALUR};

    // A bubble in execute has valid3=0, so a load pair never re-triggers itself.
    assign hazard = pipe_q.valid && (pipe_q.iclass == IC_LOAD) && (pipe_q.rd != 5'd0)
                 && ((uses_rs1 && (sel_instr[19:15] == pipe_q.rd))
                  || (uses_rs2 && (sel_instr[24:20] == pipe_q.rd)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        skid_load   = 1'b0;
        load_bubble = 1'b0;
        if (dif.kill) begin
            state_d     = ST_RUN;
            cnt_d       = 2'd0;
            load_bubble = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        skid_load   = 1'b1;
                        load_bubble = 1'b1;
                        state_d     = ST_STALL;
                        cnt_d       = 2'd0;
                    end
                end
                ST_STALL: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_RUN;
                        cnt_d   = 2'd0;
                    end else begin
                        load_bubble = 1'b1;
                        cnt_d       = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        pipe_d = '{valid: 1'b1, pc: sel_pc, instr: sel_instr, rd: sel_instr[11:7],
                   imm: sel_imm, iclass: sel_info.iclass,
                   funct3: sel_instr[14:12], f7b5: sel_instr[30]};
        if (load_bubble) begin
            pipe_d = '{valid: 1'b0, pc: pipe_q.pc, instr: NOP_INSTR, rd: 5'd0,
                       imm: 32'd0, iclass: IC_ALUI, funct3: 3'd0, f7b5: 1'b0};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_RUN;
            cnt_q        <= 2'd0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'd0;
            pipe_q       <= '{valid: 1'b0, pc: 32'd0, instr: NOP_INSTR, rd: 5'd0,
                              imm: 32'd0, iclass: IC_ALUI, funct3: 3'd0, f7b5: 1'b0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pipe_q  <= pipe_d;
            if (skid_load) begin
                skid_instr_q <= dif.instr2;
                skid_pc_q    <= dif.pc2;
            end
        end
    end

    assign dif.stall    = (state_q == ST_STALL);
    assign dif.stallnum = (state_q == ST_STALL) ? cnt_q : 2'd0;
    assign dif.rs1_addr = sel_instr[19:15];
    assign dif.rs2_addr = sel_instr[24:20];
    assign dif.pc3      = pipe_q.pc;
    assign dif.instr3   = pipe_q.instr;
    assign dif.rd3      = pipe_q.rd;
    assign dif.imm3     = pipe_q.imm;
    assign dif.iclass3  = pipe_q.iclass;
    assign dif.funct3_3 = pipe_q.funct3;
    assign dif.f7b5_3   = pipe_q.f7b5;
    assign dif.valid3   = pipe_q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (1 and 3 load-use cycles) driven in
// lockstep, compared every cycle against a behavioural model plus directed points.
module tb_decode_stage;
  import gpcore_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if if1 ();
  decode_stage_if if3 ();

  decode_stage #(.LOAD_USE_CYCLES(1)) u_dut1 (.clk(clk), .nrst(nrst), .dif(if1.slave));
  decode_stage #(.LOAD_USE_CYCLES(3)) u_dut3 (.clk(clk), .nrst(nrst), .dif(if3.slave));

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    iclass_t     iclass;
    logic [2:0]  f3;
    logic        f7b5;
  } exp_t;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI_X1  = 32'h0050_0093;
  localparam logic [31:0] LW_X5    = 32'h0001_2283;
  localparam logic [31:0] ADD_X5   = 32'h0012_8333;
  localparam logic [31:0] LW_X0    = 32'h0001_2003;
  localparam logic [31:0] ADD_X0   = 32'h0010_0333;
  localparam logic [31:0] LUI_X5   = 32'h1234_52B7;
  localparam logic [31:0] BEQ_M4   = 32'hFE00_0EE3;
  localparam logic [31:0] JAL_2048 = 32'h0010_006F;
  localparam logic [31:0] SW_M1    = 32'hFE00_2FA3;
  localparam logic [31:0] ILLEGAL  = 32'h0000_007F;

  exp_t        m_pipe    [2];
  int          m_wait    [2];
  logic [31:0] m_held    [2];
  logic [31:0] m_held_pc [2];
  int          luc       [2] = '{1, 3};
  logic [31:0] cur_instr;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic iclass_t ref_class(input logic [31:0] w);
    case (w[6:0])
      7'h33:   return IC_ALUR;
      7'h13:   return IC_ALUI;
      7'h03:   return IC_LOAD;
      7'h23:   return IC_STORE;
      7'h63:   return IC_BRANCH;
      7'h6F:   return IC_JAL;
      7'h67:   return IC_JALR;
      7'h37:   return IC_LUI;
      7'h17:   return IC_AUIPC;
      7'h73:   return IC_SYSTEM;
      default: return IC_ILLEGAL;
    endcase
  endfunction

  // Immediate values computed numerically from the field weights.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int v;
    v = 0;
    case (ref_class(w))
      IC_ALUI, IC_LOAD, IC_JALR, IC_SYSTEM: v = $signed(w) >>> 20;
      IC_STORE:  v = ($signed(w) >>> 25) * 32 + int'(w[11:7]);
      IC_BRANCH: v = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0)
                     + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      IC_JAL:    v = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096
                     + (w[20] ? 2048 : 0) + int'(w[30:21]) * 2;
      IC_LUI, IC_AUIPC: v = int'(w & 32'hFFFF_F000);
      default:   v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic exp_t ref_bubble(input logic [31:0] pc);
    return '{1'b0, pc, NOP, 32'd0, 5'd0, IC_ALUI, 3'd0, 1'b0};
  endfunction

  function automatic exp_t ref_issue(input logic [31:0] pc, input logic [31:0] w);
    return '{1'b1, pc, w, ref_imm(w), w[11:7], ref_class(w), w[14:12], w[30]};
  endfunction

  function automatic bit ref_hazard(input exp_t p, input logic [31:0] w);
    iclass_t c;
    bit r1, r2;
    if (!p.valid || p.iclass != IC_LOAD || p.rd == 5'd0) return 1'b0;
    c  = ref_class(w);
    r1 = !(c == IC_LUI || c == IC_AUIPC || c == IC_JAL);
    r2 = (c == IC_BRANCH || c == IC_STORE || c == IC_ALUR);
    return (r1 && w[19:15] == p.rd) || (r2 && w[24:20] == p.rd);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pipe[k]    = ref_bubble(32'd0);
      m_wait[k]    = 0;
      m_held[k]    = NOP;
      m_held_pc[k] = 32'd0;
    end
  endtask

  // m_wait = stall cycles still to be spent before the held instruction issues.
  task automatic model_step(input int k, input logic [31:0] pc, input logic [31:0] w,
                            input logic kl);
    if (kl) begin
      m_pipe[k] = ref_bubble(m_pipe[k].pc);
      m_wait[k] = 0;
    end else if (m_wait[k] > 0) begin
      if (m_wait[k] == 1) m_pipe[k] = ref_issue(m_held_pc[k], m_held[k]);
      else                m_pipe[k] = ref_bubble(m_pipe[k].pc);
      m_wait[k]--;
    end else if (ref_hazard(m_pipe[k], w)) begin
      m_held[k]    = w;
      m_held_pc[k] = pc;
      m_pipe[k]    = ref_bubble(m_pipe[k].pc);
      m_wait[k]    = luc[k];
    end else begin
      m_pipe[k] = ref_issue(pc, w);
    end
  endtask

  task automatic check_one(input string nm, input int k, input logic st,
                           input logic [1:0] sn, input logic [4:0] r1,
                           input logic [4:0] r2, input exp_t o);
    logic [31:0] sel;
    exp_t e;
    sel = (m_wait[k] > 0) ? m_held[k] : cur_instr;
    e   = m_pipe[k];
    check({nm, ".stall"},    32'(st), 32'(m_wait[k] > 0));
    check({nm, ".stallnum"}, 32'(sn), (m_wait[k] > 0) ? 32'(luc[k] - m_wait[k]) : 32'd0);
    check({nm, ".rs1_addr"}, 32'(r1), 32'(sel[19:15]));
    check({nm, ".rs2_addr"}, 32'(r2), 32'(sel[24:20]));
    check({nm, ".valid3"},   32'(o.valid), 32'(e.valid));
    check({nm, ".pc3"},      o.pc, e.pc);
    check({nm, ".instr3"},   o.instr, e.instr);
    check({nm, ".imm3"},     o.imm, e.imm);
    check({nm, ".rd3"},      32'(o.rd), 32'(e.rd));
    check({nm, ".iclass3"},  32'(o.iclass), 32'(e.iclass));
    check({nm, ".funct3_3"}, 32'(o.f3), 32'(e.f3));
    check({nm, ".f7b5_3"},   32'(o.f7b5), 32'(e.f7b5));
  endtask

  task automatic check_all();
    check_one("u1", 0, if1.stall, if1.stallnum, if1.rs1_addr, if1.rs2_addr,
              '{if1.valid3, if1.pc3, if1.instr3, if1.imm3, if1.rd3, if1.iclass3,
                if1.funct3_3, if1.f7b5_3});
    check_one("u3", 1, if3.stall, if3.stallnum, if3.rs1_addr, if3.rs2_addr,
              '{if3.valid3, if3.pc3, if3.instr3, if3.imm3, if3.rd3, if3.iclass3,
                if3.funct3_3, if3.f7b5_3});
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] w, input logic kl);
    if1.pc2 = pc; if1.instr2 = w; if1.kill = kl;
    if3.pc2 = pc; if3.instr2 = w; if3.kill = kl;
    cur_instr = w;
  endtask

  // One clock: drive, check at the falling edge, advance the model, settle past the rise.
  task automatic cycle(input logic [31:0] pc, input logic [31:0] w, input logic kl);
    drive(pc, w, kl);
    @(negedge clk);
    check_all();
    model_step(0, pc, w, kl);
    model_step(1, pc, w, kl);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h7F};
    w        = $urandom;
    w[6:0]   = ops[$urandom_range(0, 11)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    logic [31:0] pc;
    drive(32'd0, NOP, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    check("reset.valid3",  32'(if1.valid3), 32'd0);
    check("reset.instr3",  if1.instr3, NOP);
    check("reset.iclass3", 32'(if1.iclass3), 32'(IC_ALUI));
    check("reset.stall",   32'(if3.stall), 32'd0);
    nrst = 1'b1;

    // addi x1,x0,5 right after reset
    cycle(32'd4, ADDI_X1, 1'b0);
    check("t1.valid3",  32'(if1.valid3), 32'd1);
    check("t1.rd3",     32'(if1.rd3), 32'd1);
    check("t1.imm3",    if1.imm3, 32'd5);
    check("t1.iclass3", 32'(if1.iclass3), 32'(IC_ALUI));
    check("t1.pc3",     if1.pc3, 32'd4);
    check("t1.stall",   32'(if1.stall), 32'd0);

    // load-use: lw x5 then add x6,x5,x1 held by the frozen frontend
    cycle(32'd8, LW_X5, 1'b0);
    cycle(32'd12, ADD_X5, 1'b0);
    check("t2.u1.bubble", 32'(if1.valid3), 32'd0);
    check("t2.u1.stall",  32'(if1.stall), 32'd1);
    check("t2.u1.sn0",    32'(if1.stallnum), 32'd0);
    check("t5.u3.sn0",    32'(if3.stallnum), 32'd0);
    cycle(32'd12, ADD_X5, 1'b0);
    check("t2.u1.instr3", if1.instr3, ADD_X5);
    check("t2.u1.pc3",    if1.pc3, 32'd12);
    check("t2.u1.unstall", 32'(if1.stall), 32'd0);
    check("t5.u3.sn1",    32'(if3.stallnum), 32'd1);
    cycle(32'd12, ADD_X5, 1'b0);
    check("t5.u3.sn2",    32'(if3.stallnum), 32'd2);
    check("t5.u3.bubble", 32'(if3.valid3), 32'd0);
    cycle(32'd12, ADD_X5, 1'b0);
    check("t5.u3.instr3", if3.instr3, ADD_X5);
    check("t5.u3.pc3",    if3.pc3, 32'd12);
    check("t5.u3.valid3", 32'(if3.valid3), 32'd1);

    // x0 destination and non-reading consumer never stall
    cycle(32'd16, LW_X0, 1'b0);
    cycle(32'd20, ADD_X0, 1'b0);
    check("t3.x0.stall",  32'(if1.stall), 32'd0);
    check("t3.x0.instr3", if3.instr3, ADD_X0);
    cycle(32'd24, LW_X5, 1'b0);
    cycle(32'd28, LUI_X5, 1'b0);
    check("t3.lui.stall", 32'(if3.stall), 32'd0);
    check("t3.lui.imm3",  if1.imm3, 32'h1234_5000);

    // kill during the stall cycle squashes the skid instruction
    cycle(32'd32, LW_X5, 1'b0);
    cycle(32'd36, ADD_X5, 1'b0);
    cycle(32'd36, ADD_X5, 1'b1);
    check("t4.u1.valid3", 32'(if1.valid3), 32'd0);
    check("t4.u1.stall",  32'(if1.stall), 32'd0);
    check("t4.u3.stall",  32'(if3.stall), 32'd0);
    cycle(32'd40, ADDI_X1, 1'b0);
    check("t4.u3.instr3", if3.instr3, ADDI_X1);
    check("t4.u1.pc3",    if1.pc3, 32'd40);

    // immediate formats and illegal opcode
    cycle(32'd44, BEQ_M4, 1'b0);
    check("t6.beq.imm3", if1.imm3, 32'hFFFF_FFFC);
    cycle(32'd48, JAL_2048, 1'b0);
    check("t6.jal.imm3", if1.imm3, 32'h0000_0800);
    cycle(32'd52, SW_M1, 1'b0);
    check("t6.sw.imm3",  if1.imm3, 32'hFFFF_FFFF);
    cycle(32'd56, ILLEGAL, 1'b0);
    check("t6.ill.iclass3", 32'(if1.iclass3), 32'(IC_ILLEGAL));
    check("t6.ill.valid3",  32'(if1.valid3), 32'd1);

    // reset asserted mid-stall
    cycle(32'd60, LW_X5, 1'b0);
    cycle(32'd64, ADD_X5, 1'b0);
    nrst = 1'b0;
    #1;
    check("rst.stall",  32'(if3.stall), 32'd0);
    check("rst.instr3", if3.instr3, NOP);
    check("rst.pc3",    if1.pc3, 32'd0);
    model_reset();
    nrst = 1'b1;

    pc = 32'd100;
    for (int i = 0; i < 400; i++) begin
      cycle(pc, rand_instr(), ($urandom_range(0, 7) == 0));
      pc += 32'd4;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
